jk_cmd_sequencer: RTL and testbench

Command sequencer that drives the J/K inputs of the JK flip-flop stage. It accepts set/clear/toggle/hold commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command as a one-cycle J/K pulse with a programmable idle gap between issues, and keeps a shadow model of the flip-flop's expected q for checking and status.

---
 rtl/jk_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - buffered J/K command issuer with idle gap and shadow q model
`timescale 1ns/1ps
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [GAP_W-1:0]             cfg_gap,
    output logic                         j,
    output logic                         k,
    output logic                         issue,
    output logic                         q_model,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic               gap_last;
    logic               gap_zero;

    // Ready depends only on occupancy, so a full FIFO refuses a push even when popping.
    assign cmd_ready     = (count != CNT_W'(DEPTH));
    assign push          = cmd_valid && cmd_ready;
    assign fifo_nonempty = (count != '0);
    assign gap_last      = (gap_cnt == GAP_W'(1));
    assign gap_zero      = (cfg_gap == '0);
    assign busy          = (state != IDLE) || fifo_nonempty;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fifo_nonempty) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!gap_zero)          state_nxt = GAP;
                else if (fifo_nonempty) state_nxt = ISSUE;
                else                    state_nxt = IDLE;
            end
            GAP: begin
                if (gap_last) state_nxt = fifo_nonempty ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decision: every transition into ISSUE consumes exactly one FIFO entry
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = fifo_nonempty;
            ISSUE:   pop = gap_zero && fifo_nonempty;
            GAP:     pop = gap_last && fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    // Gap counter: loaded from cfg_gap only while issuing, counted down during GAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == ISSUE) begin
            gap_cnt <= cfg_gap;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy governs validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Registered J/K drive: a single-cycle pulse per popped command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j     <= 1'b0;
            k     <= 1'b0;
            issue <= 1'b0;
        end else if (pop) begin
            j     <= fifo_mem[rd_ptr][1];
            k     <= fifo_mem[rd_ptr][0];
            issue <= 1'b1;
        end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            issue <= 1'b0;
        end
    end

    // Shadow q: applies the J/K pair at the edge the downstream flop samples it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_model <= 1'b0;
        end else if (issue) begin
            case ({j, k})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - directed self-checking bench for jk_cmd_sequencer
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [GAP_W-1:0]   cfg_gap = '0;
    logic               j;
    logic               k;
    logic               issue;
    logic               q_model;
    logic [CNT_W-1:0]   count;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] ops2 [4]  = '{2'b10, 2'b11, 2'b11, 2'b01};
    logic       iss2 [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] jk2  [6]  = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       q2   [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       bsy2 [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] ops4 [3]  = '{2'b01, 2'b10, 2'b00};
    logic [1:0] jk4  [6]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic       q4   [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] ops6 [10] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10,
                              2'b11, 2'b01, 2'b00, 2'b11, 2'b01};

    jk_cmd_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cfg_gap   (cfg_gap),
        .j         (j),
        .k         (k),
        .issue     (issue),
        .q_model   (q_model),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int n_issued;
        int extra;
        logic acc;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_j", j, 0);
        check_eq("rst_k", k, 0);
        check_eq("rst_issue", issue, 0);
        check_eq("rst_q", q_model, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;

        // back-to-back with zero gap
        cfg_gap = 4'd0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = (c < 4);
            if (c < 4) cmd_op = ops2[c];
            tick();
            check_eq($sformatf("b2b_issue[%0d]", c), issue, iss2[c]);
            check_eq($sformatf("b2b_jk[%0d]", c), {j, k}, jk2[c]);
            check_eq($sformatf("b2b_q[%0d]", c), q_model, q2[c]);
            check_eq($sformatf("b2b_busy[%0d]", c), busy, bsy2[c]);
        end
        cmd_valid = 1'b0;

        // gap of 3 with three toggles
        cfg_gap = 4'd3;
        cmd_op  = 2'b11;
        for (int c = 0; c < 14; c++) begin
            logic ei;
            logic eq;
            cmd_valid = (c < 3);
            tick();
            ei = (c == 1) || (c == 5) || (c == 9);
            eq = (c >= 2 && c < 6) || (c >= 10);
            check_eq($sformatf("gap3_issue[%0d]", c), issue, ei);
            check_eq($sformatf("gap3_jk[%0d]", c), {j, k}, ei ? 2'b11 : 2'b00);
            check_eq($sformatf("gap3_q[%0d]", c), q_model, eq);
            check_eq($sformatf("gap3_busy[%0d]", c), busy, c < 13);
        end
        cmd_valid = 1'b0;

        // clear, set, hold with zero gap
        cfg_gap = 4'd0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = (c < 3);
            if (c < 3) cmd_op = ops4[c];
            tick();
            check_eq($sformatf("hold_issue[%0d]", c), issue, (c >= 1 && c <= 3));
            check_eq($sformatf("hold_jk[%0d]", c), {j, k}, jk4[c]);
            check_eq($sformatf("hold_q[%0d]", c), q_model, q4[c]);
        end
        cmd_valid = 1'b0;

        // gap reprogrammed from 5 to 1 mid-gap
        cfg_gap = 4'd5;
        cmd_op  = 2'b00;
        for (int c = 0; c < 13; c++) begin
            cmd_valid = (c < 3);
            tick();
            check_eq($sformatf("regap_issue[%0d]", c), issue, (c == 1) || (c == 7) || (c == 9));
            check_eq($sformatf("regap_busy[%0d]", c), busy, c < 11);
            if (c == 3) cfg_gap = 4'd1;
        end
        cmd_valid = 1'b0;
        check_eq("regap_q", q_model, 1);

        // full FIFO, held source, order across pointer wrap
        cfg_gap  = 4'd15;
        sent     = 0;
        n_issued = 0;
        for (int cyc = 0; cyc < 400 && n_issued < 10; cyc++) begin
            cmd_valid = (sent < 10);
            if (sent < 10) cmd_op = ops6[sent];
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) sent++;
            if (issue) begin
                if (n_issued < 10)
                    check_eq($sformatf("full_order[%0d]", n_issued), {j, k}, ops6[n_issued]);
                n_issued++;
            end
            if (cyc == 4) begin
                check_eq("full_count_e4", count, 4);
                check_eq("full_ready_e4", cmd_ready, 0);
            end
            if (cyc == 16) check_eq("full_ready_e16", cmd_ready, 0);
            if (cyc == 17) check_eq("full_count_e17", count, 3);
            if (cyc == 18) begin
                check_eq("full_count_e18", count, 4);
                check_eq("full_sent_e18", sent, 6);
            end
        end
        cmd_valid = 1'b0;
        check_eq("full_issued", n_issued, 10);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (issue) extra++;
        end
        check_eq("full_extra_issues", extra, 0);
        check_eq("full_q_final", q_model, 0);
        check_eq("full_count_final", count, 0);
        check_eq("full_busy_final", busy, 0);

        // asynchronous reset mid-gap with three entries queued
        cfg_gap   = 4'd15;
        cmd_op    = 2'b10;
        cmd_valid = 1'b1;
        repeat (4) tick();
        cmd_valid = 1'b0;
        check_eq("pre_rst_count", count, 3);
        check_eq("pre_rst_q", q_model, 1);
        check_eq("pre_rst_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_j", j, 0);
        check_eq("arst_k", k, 0);
        check_eq("arst_issue", issue, 0);
        check_eq("arst_q", q_model, 0);
        check_eq("arst_ready", cmd_ready, 1);
        check_eq("arst_count", count, 0);
        check_eq("arst_busy", busy, 0);
        tick();
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (issue) extra++;
        end
        check_eq("post_rst_issues", extra, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        tick();
        cmd_valid = 1'b0;
        check_eq("post_rst_push_count", count, 1);
        tick();
        check_eq("post_rst_issue", issue, 1);
        check_eq("post_rst_jk", {j, k}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
